// File: rtl/probe_axi_arb.sv
// -----------------------------------------------------------------------------
// probe_axi_arb
//
// Two-requester AXI-lite arbiter. It shares one AXI-lite master port between
// requester 0 (UART probe bus master) and requester 1 (second on-chip master).
// The owner keeps the port for one complete transaction: AR->R for a read, or
// AW+W->B for a write. Owners alternate round-robin when both requesters ask
// at once. Inside one requester, a pending read is served before a pending
// write. Apart from one cycle of arbitration latency the block is transparent.
//
// Ports
//   clk, m_aresetn            clock (rising edge), async active-low reset
//   s0_axi_* / s1_axi_*       requester slave ports (AR, R, AW, W, B)
//   m_axi_*                   shared master port towards the interconnect
//   grant[1:0]                one-hot current owner, 2'b00 when idle
//   busy                      a transaction is in progress
// -----------------------------------------------------------------------------
module probe_axi_arb (
    input  logic        clk,
    input  logic        m_aresetn,

    // requester 0
    input  logic [31:0] s0_axi_araddr,
    input  logic [2:0]  s0_axi_arsize,
    input  logic        s0_axi_arvalid,
    output logic        s0_axi_arready,
    output logic [31:0] s0_axi_rdata,
    output logic [1:0]  s0_axi_rresp,
    output logic        s0_axi_rvalid,
    input  logic        s0_axi_rready,
    input  logic [31:0] s0_axi_awaddr,
    input  logic [2:0]  s0_axi_awsize,
    input  logic        s0_axi_awvalid,
    output logic        s0_axi_awready,
    input  logic [31:0] s0_axi_wdata,
    input  logic [3:0]  s0_axi_wstrb,
    input  logic        s0_axi_wvalid,
    output logic        s0_axi_wready,
    output logic [1:0]  s0_axi_bresp,
    output logic        s0_axi_bvalid,
    input  logic        s0_axi_bready,

    // requester 1
    input  logic [31:0] s1_axi_araddr,
    input  logic [2:0]  s1_axi_arsize,
    input  logic        s1_axi_arvalid,
    output logic        s1_axi_arready,
    output logic [31:0] s1_axi_rdata,
    output logic [1:0]  s1_axi_rresp,
    output logic        s1_axi_rvalid,
    input  logic        s1_axi_rready,
    input  logic [31:0] s1_axi_awaddr,
    input  logic [2:0]  s1_axi_awsize,
    input  logic        s1_axi_awvalid,
    output logic        s1_axi_awready,
    input  logic [31:0] s1_axi_wdata,
    input  logic [3:0]  s1_axi_wstrb,
    input  logic        s1_axi_wvalid,
    output logic        s1_axi_wready,
    output logic [1:0]  s1_axi_bresp,
    output logic        s1_axi_bvalid,
    input  logic        s1_axi_bready,

    // shared master port
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arsize,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awsize,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,

    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t state, state_d;
    logic   g, g_d;             // granted requester index
    logic   lw, lw_d;           // last winner, loses the next tie
    logic   ar_done, ar_done_d;
    logic   aw_done, aw_done_d;
    logic   w_done, w_done_d;

    // Requester-side handshakes for the granted requester only.
    logic   gr_arready, gr_rvalid, gr_awready, gr_wready, gr_bvalid;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic req0, req1, win, win_arvalid;

    assign req0 = s0_axi_arvalid | s0_axi_awvalid;
    assign req1 = s1_axi_arvalid | s1_axi_awvalid;

    // A tie goes to the requester that did not win last time.
    assign win         = (req0 & req1) ? ~lw : req1;
    assign win_arvalid = win ? s1_axi_arvalid : s0_axi_arvalid;

    // ------------------------------------------------------------------
    // Granted-requester view. In IDLE the select falls back to requester 0;
    // the muxed values are don't-care there because every valid is low.
    // ------------------------------------------------------------------
    logic sel;
    assign sel = (state == IDLE) ? 1'b0 : g;

    logic sg_arvalid, sg_rready, sg_awvalid, sg_wvalid, sg_bready;

    assign sg_arvalid = sel ? s1_axi_arvalid : s0_axi_arvalid;
    assign sg_rready  = sel ? s1_axi_rready  : s0_axi_rready;
    assign sg_awvalid = sel ? s1_axi_awvalid : s0_axi_awvalid;
    assign sg_wvalid  = sel ? s1_axi_wvalid  : s0_axi_wvalid;
    assign sg_bready  = sel ? s1_axi_bready  : s0_axi_bready;

    assign m_axi_araddr = sel ? s1_axi_araddr : s0_axi_araddr;
    assign m_axi_arsize = sel ? s1_axi_arsize : s0_axi_arsize;
    assign m_axi_awaddr = sel ? s1_axi_awaddr : s0_axi_awaddr;
    assign m_axi_awsize = sel ? s1_axi_awsize : s0_axi_awsize;
    assign m_axi_wdata  = sel ? s1_axi_wdata  : s0_axi_wdata;
    assign m_axi_wstrb  = sel ? s1_axi_wstrb  : s0_axi_wstrb;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments and an async reset term in
    // the sensitivity list, so an abandoned transaction drops immediately.
    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            state   <= IDLE;
            g       <= 1'b0;
            lw      <= 1'b1;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_d;
            g       <= g_d;
            lw      <= lw_d;
            ar_done <= ar_done_d;
            aw_done <= aw_done_d;
            w_done  <= w_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and channel control
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement leaves one unassigned (no latches).
    always_comb begin
        state_d       = state;
        g_d           = g;
        lw_d          = lw;
        ar_done_d     = ar_done;
        aw_done_d     = aw_done;
        w_done_d      = w_done;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        gr_arready    = 1'b0;
        gr_rvalid     = 1'b0;
        gr_awready    = 1'b0;
        gr_wready     = 1'b0;
        gr_bvalid     = 1'b0;

        unique case (state)
            IDLE: begin
                if (req0 | req1) begin
                    g_d     = win;
                    lw_d    = win;
                    // Read beats write inside the same requester.
                    state_d = win_arvalid ? RD : WR;
                end
            end

            RD: begin
                // AR is forwarded once; R is a straight pass-through.
                m_axi_arvalid = sg_arvalid & ~ar_done;
                gr_arready    = m_axi_arready & ~ar_done;
                if (m_axi_arvalid & m_axi_arready)
                    ar_done_d = 1'b1;

                gr_rvalid    = m_axi_rvalid;
                m_axi_rready = sg_rready;
                if (m_axi_rvalid & sg_rready) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end

            WR: begin
                // AW and W complete independently, in either order.
                m_axi_awvalid = sg_awvalid & ~aw_done;
                gr_awready    = m_axi_awready & ~aw_done;
                if (m_axi_awvalid & m_axi_awready)
                    aw_done_d = 1'b1;

                m_axi_wvalid = sg_wvalid & ~w_done;
                gr_wready    = m_axi_wready & ~w_done;
                if (m_axi_wvalid & m_axi_wready)
                    w_done_d = 1'b1;

                gr_bvalid    = m_axi_bvalid;
                m_axi_bready = sg_bready;
                if (m_axi_bvalid & sg_bready) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Requester-side outputs. The gr_* terms are already zero in IDLE.
    // ------------------------------------------------------------------
    assign s0_axi_arready = gr_arready & ~g;
    assign s1_axi_arready = gr_arready &  g;
    assign s0_axi_rvalid  = gr_rvalid  & ~g;
    assign s1_axi_rvalid  = gr_rvalid  &  g;
    assign s0_axi_awready = gr_awready & ~g;
    assign s1_axi_awready = gr_awready &  g;
    assign s0_axi_wready  = gr_wready  & ~g;
    assign s1_axi_wready  = gr_wready  &  g;
    assign s0_axi_bvalid  = gr_bvalid  & ~g;
    assign s1_axi_bvalid  = gr_bvalid  &  g;

    // Read data and responses are broadcast; only the valids are steered.
    assign s0_axi_rdata = m_axi_rdata;
    assign s1_axi_rdata = m_axi_rdata;
    assign s0_axi_rresp = m_axi_rresp;
    assign s1_axi_rresp = m_axi_rresp;
    assign s0_axi_bresp = m_axi_bresp;
    assign s1_axi_bresp = m_axi_bresp;

    assign busy  = (state != IDLE);
    assign grant = busy ? {g, ~g} : 2'b00;

endmodule

// File: doc/probe_axi_arb.md
# probe_axi_arb

Two-requester AXI-lite arbiter that shares one AXI master port between the UART probe's bus master (requester 0) and a second on-chip master (requester 1, e.g. a scripted test sequencer). It grants one complete transaction at a time (read: AR→R, write: AW+W→B), with round-robin fairness between requesters and read-before-write priority within a requester. It sits between the masters and the interconnect, and is transparent apart from one cycle of arbitration latency.

## Interface
- No parameters; all widths fixed (32-bit address and data, 4-bit strobe).
- clk  in  1  system clock; all logic on rising edge
- m_aresetn  in  1  asynchronous, active-low reset
- s0_axi_araddr / s1_axi_araddr  in  32  requester read address
- s0_axi_arsize / s1_axi_arsize  in  3  requester read size
- s0_axi_arvalid / s1_axi_arvalid  in  1  read request
- s0_axi_arready / s1_axi_arready  out  1  read address accepted
- s0_axi_rdata / s1_axi_rdata  out  32  read data; both driven from m_axi_rdata
- s0_axi_rresp / s1_axi_rresp  out  2  read response; both driven from m_axi_rresp
- s0_axi_rvalid / s1_axi_rvalid  out  1  read data valid, granted requester only
- s0_axi_rready / s1_axi_rready  in  1  read data accept
- s0_axi_awaddr, s0_axi_awsize, s0_axi_awvalid (in 32/3/1), s0_axi_awready (out 1); same set for s1_  write address channel
- s0_axi_wdata, s0_axi_wstrb, s0_axi_wvalid (in 32/4/1), s0_axi_wready (out 1); same set for s1_  write data channel
- s0_axi_bresp, s0_axi_bvalid (out 2/1), s0_axi_bready (in 1); same set for s1_  write response; bresp is broadcast from m_axi_bresp
- m_axi_araddr, m_axi_arsize, m_axi_arvalid, m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid, m_axi_rready  master read channels; outputs are araddr, arsize, arvalid and rready
- m_axi_awaddr, m_axi_awsize, m_axi_awvalid, m_axi_awready, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_wready, m_axi_bresp, m_axi_bvalid, m_axi_bready  master write channels; outputs are awaddr, awsize, awvalid, wdata, wstrb, wvalid and bready
- grant  out  2  one-hot current owner (bit i = requester i); 2'b00 when idle
- busy  out  1  transaction in progress (state != IDLE)

## Operation
- State register: IDLE, RD, WR, plus grant index g and last-winner bit lw.
- Request: req_i = sI_axi_arvalid | sI_axi_awvalid.
- IDLE winner: the only requester requesting; on a tie, requester !lw. On grant, lw <= winner.
- IDLE next state: RD if the winner's arvalid=1, else WR. Read beats write for the same requester.
- RD: m_axi_arvalid = sg_arvalid & !ar_done, and sg_arready = m_axi_arready & !ar_done.
  - ar_done sets on the AR handshake.
  - R channel passes through (sg_rvalid = m_axi_rvalid, m_axi_rready = sg_rready).
  - Transaction ends on the R handshake.
- WR: AW and W are forwarded independently, each gated by its own done flag (aw_done, w_done).
  - B passes through to the granted requester only.
  - Transaction ends on the B handshake.
- On transaction end: next state IDLE, grant cleared, done flags cleared.
- Non-granted requester: arready, awready, wready, rvalid and bvalid are all 0.
- In IDLE: all m_axi_*valid = 0 and m_axi_rready = m_axi_bready = 0.
- Address, size, data and strobe muxes select requester g. In IDLE they select requester 0; the value is don't-care because valids are 0.
- Reset values:
  - state IDLE, grant 2'b00, busy 0, lw 1 (requester 0 wins the first tie), all done flags 0.
  - All valid and ready outputs are 0.
- Reset mid-transaction: the transaction is abandoned and outputs drop asynchronously. The master interconnect is reset by the same m_aresetn.

## Timing
- Arbitration latency: a request seen in IDLE at cycle 0 gives grant/busy at cycle 1, with m_axi_arvalid or awvalid high at cycle 1 if the request is still held.
- Back-to-back: a response handshake at cycle N gives IDLE at N+1 and the next grant at N+2. Minimum read occupancy is 3 cycles (grant, AR, R when the slave responds immediately).
- Request withdrawal: a requester dropping arvalid/awvalid while IDLE and not yet granted is legal and causes no grant. After grant, AXI rules require the valid to be held.
- Read and write pending in the same requester: the read is served first and the write is arbitrated afresh afterwards, so the other requester may win in between.
- AW and W may complete in either order or the same cycle. Each is forwarded exactly once.
- m_axi_bvalid/rvalid outside the matching state are ignored (ready stays 0) and never reach a requester.

## Test plan
- Single read, s0: araddr 0x0000_0010 → grant 2'b01 at cycle 1. m_axi_araddr = 0x10. Slave returns rdata 0x0000_00A5, resp 0 → s0_rvalid with 0xA5; s1_rvalid stays 0; busy drops after R.
- Simultaneous s0 and s1 reads after reset → s0 served first, then s1; repeat → order s0, s1, s0, s1.
- s1 holds both arvalid and awvalid (wdata 0x5A, strb 4'b0001) with s0 idle → read completes first, then write. m_axi_wdata = 0x5A, and bresp 2'b10 reaches s1 only.
- Write with W handshake 3 cycles before AW → each channel is forwarded once. m_axi_wvalid drops after its handshake, and B ends the transaction.
- Stalled slave (arready low for 20 cycles) while s0 also requests → grant stays on s1 and s0_arready = 0 throughout; s0 is served after R.
- m_aresetn pulsed low mid-RD → grant = 0, busy = 0 and m_axi_arvalid = 0 immediately. After release, the first tie goes to s0.
